pio_in_capture: RTL and testbench

Parametrised multi-channel Avalon-MM input PIO, the successor to the single-channel 8-bit read-only input ports in Computer_System. Each channel synchronises an external input bus, exposes its current value, latches selected edges into a write-1-to-clear capture register, and drives a maskable interrupt. Sits on the HPS/Nios lightweight bridge as an Avalon-MM slave with one cycle of read latency. It replaces per-signal PIO instances such as the pin-position inputs.

---
 rtl/pio_in_capture.sv | 133 +++++++++++++
 tb/tb_pio_in_capture.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pio_in_capture.sv
// Multi-channel Avalon-MM input PIO: synchronised input data, edge capture with
// write-1-to-clear, per-channel interrupt mask and a single level interrupt.
module pio_in_capture #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_CH      = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2,
    localparam int AW         = (NUM_CH > 1) ? $clog2(NUM_CH) + 2 : 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [AW-1:0]                address,
    input  logic                         chipselect,
    input  logic                         write_n,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_port,
    output logic                         irq
);

    localparam int W = NUM_CH * DATA_WIDTH;

    typedef enum logic [1:0] {
        OFF_DATA  = 2'd0,
        OFF_RSVD  = 2'd1,
        OFF_MASK  = 2'd2,
        OFF_ECAP  = 2'd3
    } reg_off_e;

    logic [W-1:0]          r_sync [SYNC_STAGES];
    logic [W-1:0]          r_prev;
    logic [2:0]            r_arm_cnt;
    logic                  r_armed;
    logic [DATA_WIDTH-1:0] r_mask [NUM_CH];
    logic [DATA_WIDTH-1:0] r_ecap [NUM_CH];

    logic [W-1:0]          w_s;
    logic [W-1:0]          w_edge;
    logic                  w_wr;
    int                    w_ch;
    reg_off_e              w_off;
    logic [DATA_WIDTH-1:0] w_clr [NUM_CH];
    logic [31:0]           w_rdata;
    logic                  w_irq;
    logic                  w_unused;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_wr     = chipselect & ~write_n;
    assign w_ch     = int'(address >> 2);
    assign w_off    = reg_off_e'(address[1:0]);
    assign w_unused = ^writedata;

    always_comb begin
        case (EDGE_TYPE)
            0:       w_edge = w_s & ~r_prev;
            1:       w_edge = ~w_s & r_prev;
            default: w_edge = w_s ^ r_prev;
        endcase
    end

    // NOTE: every register, including the small per-channel arrays, is reset
    // asynchronously; the arming logic relies on the chain starting from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_prev    <= '0;
            r_arm_cnt <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= w_s;
            if (!r_armed) begin
                if (r_arm_cnt == 3'(SYNC_STAGES)) r_armed <= 1'b1;
                else                              r_arm_cnt <= r_arm_cnt + 3'd1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_clr[c] = '0;
            if (w_wr && w_ch == c && w_off == OFF_ECAP)
                w_clr[c] = writedata[DATA_WIDTH-1:0];
        end
    end

    // Set is ORed in after the clear so a simultaneous edge keeps the bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_mask[c] <= '0;
                r_ecap[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_wr && w_ch == c && w_off == OFF_MASK)
                    r_mask[c] <= writedata[DATA_WIDTH-1:0];
                r_ecap[c] <= (r_ecap[c] & ~w_clr[c])
                           | (w_edge[c*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_armed}});
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_ch == c) begin
                case (w_off)
                    OFF_DATA: w_rdata[DATA_WIDTH-1:0] = w_s[c*DATA_WIDTH +: DATA_WIDTH];
                    OFF_MASK: w_rdata[DATA_WIDTH-1:0] = r_mask[c];
                    OFF_ECAP: w_rdata[DATA_WIDTH-1:0] = r_ecap[c];
                    default:  w_rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= w_rdata;
    end

    always_comb begin
        w_irq = 1'b0;
        for (int c = 0; c < NUM_CH; c++) w_irq = w_irq | (|(r_ecap[c] & r_mask[c]));
    end

    assign irq = w_irq;

endmodule

// File: tb/tb_pio_in_capture.sv
// Directed bench for pio_in_capture: a default instance (8 bits, 2 channels,
// rising) and a 3-channel any-edge instance sharing clock and reset.
module tb_pio_in_capture;

    logic        clk = 1'b0;
    logic        reset_n;

    logic [2:0]  a0;
    logic        cs0, wn0;
    logic [31:0] wd0, rd0;
    logic [15:0] in0;
    logic        irq0;

    logic [3:0]  a1;
    logic        cs1, wn1;
    logic [31:0] wd1, rd1;
    logic [23:0] in1;
    logic        irq1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pio_in_capture #(.DATA_WIDTH(8), .NUM_CH(2), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(a0), .chipselect(cs0), .write_n(wn0),
        .writedata(wd0), .readdata(rd0), .in_port(in0), .irq(irq0)
    );

    pio_in_capture #(.DATA_WIDTH(8), .NUM_CH(3), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(a1), .chipselect(cs1), .write_n(wn1),
        .writedata(wd1), .readdata(rd1), .in_port(in1), .irq(irq1)
    );

    // Bus tasks are entered just after a falling edge; the access happens on
    // the next rising edge and they return on the falling edge after it.
    task automatic bus_write(input int sel, input logic [3:0] addr, input logic [31:0] data);
        if (sel == 0) begin a0 = addr[2:0]; wd0 = data; cs0 = 1'b1; wn0 = 1'b0; end
        else          begin a1 = addr;      wd1 = data; cs1 = 1'b1; wn1 = 1'b0; end
        @(negedge clk);
        cs0 = 1'b0; wn0 = 1'b1; cs1 = 1'b0; wn1 = 1'b1;
    endtask

    task automatic bus_read(input int sel, input logic [3:0] addr, output logic [31:0] data);
        if (sel == 0) a0 = addr[2:0];
        else          a1 = addr;
        @(negedge clk);
        data = (sel == 0) ? rd0 : rd1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset_n = 1'b0;
        in0 = '1; in1 = '1; a0 = 3'd4; a1 = 4'd0;
        repeat (3) @(negedge clk);
        total++; if (rd0 !== 32'h0) begin bad++; $display("FAIL rst_rd0: got %h want 0", rd0); end
        total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL rst_irq0: got %b want 0", irq0); end
        total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL rst_rd1: got %h want 0", rd1); end
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        bus_read(0, 4'd0, v);
        total++; if (v !== 32'hFF) begin bad++; $display("FAIL rst_ch0_data: got %h want ff", v); end
        bus_read(0, 4'd4, v);
        total++; if (v !== 32'hFF) begin bad++; $display("FAIL rst_ch1_data: got %h want ff", v); end
        bus_read(0, 4'd3, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_ch0_ecap: got %h want 0", v); end
        bus_read(0, 4'd7, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_ch1_ecap: got %h want 0", v); end
        bus_read(1, 4'd3, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_d1_ecap: got %h want 0", v); end
        total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL rst_irq_after: got %b want 0", irq0); end
    endtask

    task automatic test_capture();
        logic [31:0] v;
        in0 = 16'h00FF;
        repeat (4) @(negedge clk);
        bus_write(0, 4'd6, 32'h01);
        bus_read(0, 4'd6, v);
        total++; if (v !== 32'h01) begin bad++; $display("FAIL cap_mask_rb: got %h want 01", v); end
        in0 = 16'h81FF;
        @(negedge clk);
        total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL cap_irq_e0: got %b want 0", irq0); end
        @(negedge clk);
        total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL cap_irq_e1: got %b want 0", irq0); end
        @(negedge clk);
        total++; if (irq0 !== 1'b1) begin bad++; $display("FAIL cap_irq_e2: got %b want 1", irq0); end
        bus_read(0, 4'd7, v);
        total++; if (v !== 32'h81) begin bad++; $display("FAIL cap_ecap: got %h want 81", v); end
        bus_read(0, 4'd5, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL cap_rsvd: got %h want 0", v); end
        a0 = 3'd4;
        #1;
        total++; if (rd0 !== 32'h0) begin bad++; $display("FAIL cap_lat_early: got %h want 0", rd0); end
        @(negedge clk);
        total++; if (rd0 !== 32'h81) begin bad++; $display("FAIL cap_data: got %h want 81", rd0); end
    endtask

    task automatic test_w1c();
        logic [31:0] v;
        bus_write(0, 4'd7, 32'h01);
        total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL w1c_irq: got %b want 0", irq0); end
        bus_read(0, 4'd7, v);
        total++; if (v !== 32'h80) begin bad++; $display("FAIL w1c_ecap1: got %h want 80", v); end
        bus_write(0, 4'd7, 32'h80);
        bus_read(0, 4'd7, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL w1c_ecap2: got %h want 0", v); end
        bus_write(0, 4'd4, 32'hFF);
        bus_read(0, 4'd6, v);
        total++; if (v !== 32'h01) begin bad++; $display("FAIL w1c_ro_write: got %h want 01", v); end
    endtask

    task automatic test_set_wins();
        logic [31:0] v;
        in0 = 16'h81F7;
        repeat (4) @(negedge clk);
        in0 = 16'h81FF;
        repeat (4) @(negedge clk);
        bus_read(0, 4'd3, v);
        total++; if (v !== 32'h08) begin bad++; $display("FAIL sw_pre: got %h want 08", v); end
        in0 = 16'h81F7;
        repeat (4) @(negedge clk);
        in0 = 16'h81FF;
        repeat (2) @(negedge clk);
        bus_write(0, 4'd3, 32'h08);
        bus_read(0, 4'd3, v);
        total++; if (v !== 32'h08) begin bad++; $display("FAIL sw_same_cycle: got %h want 08", v); end
        bus_write(0, 4'd3, 32'h08);
        bus_read(0, 4'd3, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL sw_plain_clr: got %h want 0", v); end
    endtask

    task automatic test_any_edge();
        logic [31:0] v;
        in1 = 24'hFFFFFE;
        repeat (2) @(negedge clk);
        in1 = 24'hFFFFFF;
        repeat (5) @(negedge clk);
        bus_read(1, 4'd3, v);
        total++; if (v !== 32'h01) begin bad++; $display("FAIL any_ecap: got %h want 01", v); end
        total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL any_irq_masked: got %b want 0", irq1); end
        bus_write(1, 4'd2, 32'h01);
        total++; if (irq1 !== 1'b1) begin bad++; $display("FAIL any_irq_unmask: got %b want 1", irq1); end
        bus_read(1, 4'd0, v);
        total++; if (v !== 32'hFF) begin bad++; $display("FAIL any_data: got %h want ff", v); end
    endtask

    task automatic test_bad_channel();
        logic [31:0] v;
        bus_read(1, 4'hC, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL ch3_data: got %h want 0", v); end
        bus_write(1, 4'hE, 32'hFF);
        bus_read(1, 4'hE, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL ch3_mask: got %h want 0", v); end
        bus_read(1, 4'd2, v);
        total++; if (v !== 32'h01) begin bad++; $display("FAIL ch0_mask_kept: got %h want 01", v); end
        bus_read(1, 4'd6, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL ch1_mask_kept: got %h want 0", v); end
        bus_read(1, 4'hA, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL ch2_mask_kept: got %h want 0", v); end
        bus_read(1, 4'd8, v);
        total++; if (v !== 32'hFF) begin bad++; $display("FAIL ch2_data: got %h want ff", v); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        #2 reset_n = 1'b0;
        #1;
        total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL mid_irq1: got %b want 0", irq1); end
        total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL mid_rd1: got %h want 0", rd1); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        bus_read(0, 4'd3, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL mid_ch0_ecap: got %h want 0", v); end
        bus_read(0, 4'd7, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL mid_ch1_ecap: got %h want 0", v); end
        bus_read(0, 4'd6, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL mid_mask: got %h want 0", v); end
        bus_read(1, 4'd3, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL mid_d1_ecap: got %h want 0", v); end
    endtask

    initial begin
        reset_n = 1'b0;
        a0 = '0; cs0 = 1'b0; wn0 = 1'b1; wd0 = '0; in0 = '1;
        a1 = '0; cs1 = 1'b0; wn1 = 1'b1; wd1 = '0; in1 = '1;
        @(negedge clk);
        test_reset();
        test_capture();
        test_w1c();
        test_set_wins();
        test_any_edge();
        test_bad_channel();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
